// File: rtl/up_down_cntr_param.sv
// Parametrised synchronous up/down counter with wrap/saturate modes,
// parallel load, registered Gray output, wrap pulse and terminal count.
module up_down_cntr_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = (1 << WIDTH) - 1,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q, wrap_d;
    logic             at_top, at_bot;

    assign at_top = (q_q == MAX_V);
    assign at_bot = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    wrap_d = 1'b1;
                    q_d    = SATURATE ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    wrap_d = 1'b1;
                    q_d    = SATURATE ? q_q : MAX_V;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray is derived from the next-state value so it stays aligned with Q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_V;
            gray_q <= RST_V ^ (RST_V >> 1);
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            gray_q <= q_d ^ (q_d >> 1);
            wrap_q <= wrap_d;
        end
    end

    assign tc     = en & ~load & ((up_dn & at_top) | (~up_dn & at_bot));
    assign Q      = q_q;
    assign Q_gray = gray_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_up_down_cntr_param.sv
// Scoreboard bench: four counter configurations share one stimulus stream and
// are checked against a plain-arithmetic reference model.
module tb_up_down_cntr_param;

    localparam int N = 4;
    // Instance configs: {MAX, SATURATE, RST_VAL}
    localparam int MAXV [N] = '{15, 9, 9, 15};
    localparam int SATV [N] = '{0, 0, 1, 0};
    localparam int RSTV [N] = '{0, 0, 0, 5};

    logic       clk;
    logic       rst, en, up_dn, load;
    logic [3:0] load_val;
    logic [N-1:0][3:0] dq, dg;
    logic [N-1:0]      dtc, dwrap;

    typedef struct packed {
        logic              chk_tc;
        logic              chk_st;
        logic [N-1:0]      tc;
        logic [N-1:0]      w;
        logic [N-1:0][3:0] q;
        logic [N-1:0][3:0] g;
    } exp_t;

    exp_t tcq[$];
    exp_t stq[$];

    int vectors;
    int miscompares;
    int mq [N];
    bit known;

    up_down_cntr_param #(.WIDTH(4), .MAX(15), .SATURATE(1'b0), .RST_VAL(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .Q(dq[0]), .Q_gray(dg[0]), .tc(dtc[0]), .wrap(dwrap[0]));
    up_down_cntr_param #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .RST_VAL(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .Q(dq[1]), .Q_gray(dg[1]), .tc(dtc[1]), .wrap(dwrap[1]));
    up_down_cntr_param #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .RST_VAL(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .Q(dq[2]), .Q_gray(dg[2]), .tc(dtc[2]), .wrap(dwrap[2]));
    up_down_cntr_param #(.WIDTH(4), .MAX(15), .SATURATE(1'b0), .RST_VAL(5)) u3 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .Q(dq[3]), .Q_gray(dg[3]), .tc(dtc[3]), .wrap(dwrap[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and push the model's expectations.
    task automatic step(input logic r, input logic l, input logic [3:0] lv,
                        input logic e, input logic u);
        exp_t x;
        int   nq;
        bit   w;
        @(posedge clk);
        #3;
        rst = r; load = l; load_val = lv; en = e; up_dn = u;
        x = '0;
        x.chk_tc = known;
        for (int i = 0; i < N; i++) begin
            x.tc[i] = e && !l && ((u && mq[i] == MAXV[i]) || (!u && mq[i] == 0));
            w  = 1'b0;
            nq = mq[i];
            if (r) begin
                nq = RSTV[i];
            end else if (l) begin
                nq = (int'(lv) > MAXV[i]) ? MAXV[i] : int'(lv);
            end else if (e) begin
                if (u) begin
                    if (mq[i] < MAXV[i]) nq = mq[i] + 1;
                    else begin w = 1'b1; nq = SATV[i] ? mq[i] : 0; end
                end else begin
                    if (mq[i] > 0) nq = mq[i] - 1;
                    else begin w = 1'b1; nq = SATV[i] ? 0 : MAXV[i]; end
                end
            end
            mq[i]  = nq;
            x.q[i] = 4'(nq);
            x.g[i] = 4'(nq ^ (nq >> 1));
            x.w[i] = w;
        end
        if (r || l) known = 1'b1;
        x.chk_st = known;
        tcq.push_back(x);
        stq.push_back(x);
    endtask

    // tc monitor: sampled mid-cycle with inputs and state stable.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (tcq.size() != 0) begin
                x = tcq.pop_front();
                if (x.chk_tc) begin
                    for (int i = 0; i < N; i++) begin
                        vectors++;
                        if (dtc[i] !== x.tc[i]) begin
                            miscompares++;
                            $display("FAIL tc[%0d] t=%0t got %b want %b", i, $time, dtc[i], x.tc[i]);
                        end
                    end
                end
            end
        end
    end

    // Registered-output monitor: sampled just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (stq.size() != 0) begin
                x = stq.pop_front();
                if (x.chk_st) begin
                    for (int i = 0; i < N; i++) begin
                        vectors++;
                        if (dq[i] !== x.q[i] || dg[i] !== x.g[i] || dwrap[i] !== x.w[i]) begin
                            miscompares++;
                            $display("FAIL state[%0d] t=%0t got Q=%0d gray=%0d wrap=%b want Q=%0d gray=%0d wrap=%b",
                                     i, $time, dq[i], dg[i], dwrap[i], x.q[i], x.g[i], x.w[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0; known = 1'b0;
        for (int i = 0; i < N; i++) mq[i] = 0;
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;

        // Reset then count up through a wrap
        repeat (5) step(1, 0, 0, 0, 1);
        repeat (20) step(0, 0, 0, 1, 1);
        // Decade down-count from 3
        step(0, 1, 3, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        // Saturation upward from 7 and downward from 1
        step(0, 1, 7, 0, 1);
        repeat (5) step(0, 0, 0, 1, 1);
        step(0, 1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        // Load priority over en, clamp, and rst over load
        step(0, 1, 12, 1, 1);
        step(1, 1, 12, 1, 1);
        // Reset mid-count, then resume
        step(0, 1, 13, 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1, 1);
        // Hold, then direction change at the top
        step(0, 1, 6, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        step(0, 1, 15, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (tcq.size() != 0 || stq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d/%0d pending want 0/0", tcq.size(), stq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
